// File: rtl/uart_tx_core_if.sv
// Producer-to-serializer handshake bundle for uart_tx_core.
// Data moves when tx_valid and tx_ready are both high at a rising clock edge.
interface uart_tx_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_core.sv
// Parametrised UART serializer: start, DATA_WIDTH bits LSB first, optional parity, 1-2 stops.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry holding FIFO in front of the serializer.
module uart_tx_core #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_core_if.slave               bus,
  output logic                        tx_out,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int BAUD_DIV = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int IW       = $clog2(DATA_WIDTH);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_core: BAUD_DIV must be at least 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_core: DATA_WIDTH must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         baud_cnt, cnt_nxt;
  logic [IW-1:0]         bit_idx, bit_nxt;
  logic                  stop_idx, stop_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  par_bit, par_nxt;
  logic                  txo_nxt;

  logic                  bit_end, last_stop, load_point, load, avail;
  logic [DATA_WIDTH-1:0] head;

  assign bit_end    = (baud_cnt == CW'(BAUD_DIV - 1));
  assign last_stop  = (state == S_STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
  // A new frame may be loaded from idle or on the very last stop cycle (gap-free chaining).
  assign load_point = (state == S_IDLE) || last_stop;
  assign load       = load_point && avail;

  assign tx_busy = (state != S_IDLE);
  assign tx_done = last_stop;

`ifdef UART_TX_FIFO_EN
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [LW-1:0]         level;
  logic                  full, push, pop;

  assign full         = (level == LW'(FIFO_DEPTH));
  assign bus.tx_ready = !rst && !full;
  assign push         = bus.tx_valid && bus.tx_ready;
  assign pop          = load;
  assign avail        = (level != '0);
  assign head         = mem[rptr];
  assign fifo_level   = level;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.tx_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
`else
  assign bus.tx_ready = !rst && load_point;
  assign avail        = bus.tx_valid;
  assign head         = bus.tx_data;
  assign fifo_level   = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= cnt_nxt;
      bit_idx  <= bit_nxt;
      stop_idx <= stop_nxt;
      shreg    <= shreg_nxt;
      par_bit  <= par_nxt;
      tx_out   <= txo_nxt;
    end
  end

  // tx_out is computed one cycle ahead so the line comes straight from a flop.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    bit_nxt   = bit_idx;
    stop_nxt  = stop_idx;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    txo_nxt   = tx_out;
    if (state != S_IDLE) cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
    case (state)
      S_IDLE: txo_nxt = 1'b1;
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          bit_nxt   = '0;
          txo_nxt   = shreg[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == IW'(DATA_WIDTH - 1)) begin
            if (PARITY != 0) begin
              state_nxt = S_PARITY;
              txo_nxt   = par_bit;
            end else begin
              state_nxt = S_STOP;
              stop_nxt  = 1'b0;
              txo_nxt   = 1'b1;
            end
          end else begin
            bit_nxt   = bit_idx + 1'b1;
            shreg_nxt = shreg >> 1;
            txo_nxt   = shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nxt = S_STOP;
          stop_nxt  = 1'b0;
          txo_nxt   = 1'b1;
        end
      end
      S_STOP: begin
        if (last_stop) state_nxt = S_IDLE;
        else if (bit_end) stop_nxt = stop_idx + 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
        txo_nxt   = 1'b1;
      end
    endcase
    if (load) begin
      state_nxt = S_START;
      cnt_nxt   = '0;
      shreg_nxt = head;
      par_nxt   = (^head) ^ (PARITY == 1);
      txo_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: three configurations (8N1, 8E2, 5O1) at BAUD_DIV=10.
// Line monitors decode frames and compare them against a queue filled at transfer time.
module tb_uart_tx_core;
  localparam int CF = 1000000;
  localparam int BR = 100000;
  localparam int BD = 10;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_core_if #(.DATA_WIDTH(8)) b0 ();
  uart_tx_core_if #(.DATA_WIDTH(8)) b1 ();
  uart_tx_core_if #(.DATA_WIDTH(5)) b2 ();

  logic [2:0] out, busy, done, rdy;
  logic [2:0] lvl0, lvl1, lvl2;
  assign rdy = {b2.tx_ready, b1.tx_ready, b0.tx_ready};

  uart_tx_core #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1))
    d0 (.clk(clk), .rst(rst), .bus(b0.slave), .tx_out(out[0]), .tx_busy(busy[0]),
        .tx_done(done[0]), .fifo_level(lvl0));
  uart_tx_core #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2))
    d1 (.clk(clk), .rst(rst), .bus(b1.slave), .tx_out(out[1]), .tx_busy(busy[1]),
        .tx_done(done[1]), .fifo_level(lvl1));
  uart_tx_core #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_WIDTH(5), .PARITY(1), .STOP_BITS(1))
    d2 (.clk(clk), .rst(rst), .bus(b2.slave), .tx_out(out[2]), .tx_busy(busy[2]),
        .tx_done(done[2]), .fifo_level(lvl2));

  typedef struct {
    logic [15:0] bits;
  } frm_t;

  typedef struct {
    int         k;
    logic [8:0] d;
    logic       p;
    int         f;
  } vec_t;

  frm_t q0[$], q1[$], q2[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   rst_ep = 0;

  function automatic int dw(input int k);
    return (k == 2) ? 5 : 8;
  endfunction
  function automatic int has_par(input int k);
    return (k == 0) ? 0 : 1;
  endfunction
  function automatic int stp(input int k);
    return (k == 1) ? 2 : 1;
  endfunction
  function automatic int nbits(input int k);
    return 1 + dw(k) + has_par(k) + stp(k);
  endfunction

  function automatic logic [2:0] lvl(input int k);
    case (k)
      0:       return lvl0;
      1:       return lvl1;
      default: return lvl2;
    endcase
  endfunction

  function automatic frm_t mk(input int k, input logic [8:0] d, input logic p);
    frm_t f;
    int   idx;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < dw(k); i++) f.bits[1+i] = d[i];
    idx = 1 + dw(k);
    if (has_par(k) != 0) f.bits[idx] = p;
    return f;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input frm_t f);
    case (k)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endtask

  task automatic pop(input int k, output frm_t f, output bit ok);
    ok = 1'b0;
    f.bits = '0;
    case (k)
      0:       if (q0.size() > 0) begin f = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin f = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin f = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic drive(input int k, input logic v, input logic [8:0] d);
    case (k)
      0:       begin b0.tx_valid = v; b0.tx_data = d[7:0]; end
      1:       begin b1.tx_valid = v; b1.tx_data = d[7:0]; end
      default: begin b2.tx_valid = v; b2.tx_data = d[4:0]; end
    endcase
  endtask

  // Samples each bit mid-way; frames cut short by a reset are dropped from the queue unchecked.
  task automatic mon(input int k);
    frm_t        e;
    logic [15:0] got;
    int          ep;
    bit          ok;
    forever begin
      @(negedge clk);
      if (out[k] === 1'b0) begin
        ep  = rst_ep;
        got = '1;
        repeat (BD / 2 - 1) @(negedge clk);
        got[0] = out[k];
        for (int i = 1; i < nbits(k); i++) begin
          repeat (BD) @(negedge clk);
          got[i] = out[k];
        end
        pop(k, e, ok);
        if (ep == rst_ep) begin
          if (!ok) check($sformatf("unexpected_frame%0d", k), 32'(got), 32'hFFFF);
          else     check($sformatf("frame%0d", k), 32'(got), 32'(e.bits));
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  task automatic send_one(input int k, input logic [8:0] d, input logic p, input int f);
    int n, first_low, rlow, bhigh;
    @(negedge clk);
    drive(k, 1'b1, d);
    check("ready_before_xfer", 32'(rdy[k]), 1);
    push(k, mk(k, d, p));
    @(posedge clk);
    #1 drive(k, 1'b0, '0);
    n = 0; first_low = 0; rlow = 0; bhigh = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (!rdy[k]) rlow++;
      if (busy[k]) bhigh++;
      if (first_low == 0 && out[k] == 1'b0) first_low = n;
      if (done[k]) break;
    end
    check($sformatf("done_cycle k%0d d%0h", k, d), n, f + LAT - 1);
    check("first_low", first_low, LAT);
    check("busy_cycles", bhigh, f);
    check("level_at_done", 32'(lvl(k)), 0);
`ifdef UART_TX_FIFO_EN
    check("ready_low_cycles", rlow, 0);
`else
    check("ready_low_cycles", rlow, f - 1);
`endif
    @(negedge clk);
    check("idle_after_done", {29'd0, busy[k], out[k], done[k]}, 32'b010);
  endtask

  initial begin
    vec_t tbl[8];
    int   c, d1, d2, xf;
    bit   acc;
    tbl[0] = '{0, 9'hA5, 1'b0, 100};
    tbl[1] = '{0, 9'h00, 1'b0, 100};
    tbl[2] = '{0, 9'hFF, 1'b0, 100};
    tbl[3] = '{1, 9'hA5, 1'b0, 120};
    tbl[4] = '{1, 9'h07, 1'b1, 120};
    tbl[5] = '{2, 9'h1F, 1'b0, 80};
    tbl[6] = '{2, 9'h03, 1'b1, 80};
    tbl[7] = '{2, 9'h10, 1'b0, 80};
    for (int k = 0; k < 3; k++) drive(k, 1'b0, '0);

    @(negedge clk);
    check("rst_out", 32'(out), 32'b111);
    check("rst_ready", 32'(rdy), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_level", {lvl2, lvl1, lvl0}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) send_one(tbl[i].k, tbl[i].d, tbl[i].p, tbl[i].f);

    // Back-to-back frames on the 8E2 instance with tx_valid held high.
    @(negedge clk);
    drive(1, 1'b1, 9'h55);
    push(1, mk(1, 9'h55, 1'b0));
    c = 0; d1 = 0; d2 = 0; xf = 0;
    while (d2 == 0 && c < 400) begin
      if (done[1]) begin
        if (d1 == 0) begin
          d1 = c;
          check("b2b_ready_at_done", 32'(rdy[1]), 1);
        end else d2 = c;
      end
      if (d1 != 0 && c == d1 + 1) check("b2b_no_gap", {30'd0, out[1], busy[1]}, 32'b01);
      acc = rdy[1] && b1.tx_valid;
      if (acc) begin
        @(posedge clk);
        #1 xf++;
        if (xf == 1) begin
          drive(1, 1'b1, 9'hAA);
          push(1, mk(1, 9'hAA, 1'b0));
        end else drive(1, 1'b0, '0);
      end
      @(negedge clk);
      c++;
    end
    check("b2b_first_done", d1, 120 + LAT - 1);
    check("b2b_spacing", d2 - d1, 120);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 (a zero bit of 0xF0), then a clean frame.
    @(negedge clk);
    drive(0, 1'b1, 9'hF0);
    push(0, mk(0, 9'hF0, 1'b0));
    @(posedge clk);
    #1 drive(0, 1'b0, '0);
    repeat (45 + LAT - 1) @(negedge clk);
    check("bit3_low", {30'd0, out[0], busy[0]}, 32'b01);
    #2 rst = 1'b1;
    rst_ep++;
    #1;
    check("async_rst_out", 32'(out[0]), 1);
    check("async_rst_busy", 32'(busy[0]), 0);
    check("async_rst_ready", 32'(rdy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    send_one(0, 9'h3C, 1'b0, 100);

`ifdef UART_TX_FIFO_EN
    begin
      logic [8:0] bd[6];
      int         i;
      bit         saw_full;
      bd[0] = 9'h11; bd[1] = 9'h22; bd[2] = 9'h33;
      bd[3] = 9'h44; bd[4] = 9'h55; bd[5] = 9'h66;
      @(negedge clk);
      i = 0; c = 0; saw_full = 1'b0;
      drive(0, 1'b1, bd[0]);
      while (i < 6 && c < 2000) begin
        if (lvl0 == 3'd4 && !saw_full) begin
          saw_full = 1'b1;
          check("full_ready_low", 32'(rdy[0]), 0);
        end
        if (rdy[0]) begin
          push(0, mk(0, bd[i], 1'b0));
          @(posedge clk);
          #1 i++;
          if (i < 6) drive(0, 1'b1, bd[i]);
          else       drive(0, 1'b0, '0);
        end
        @(negedge clk);
        c++;
      end
      check("burst_accepted", i, 6);
      check("burst_saw_full", 32'(saw_full), 1);
      c = 0;
      while ((lvl0 != 0 || busy[0]) && c < 1000) begin
        @(negedge clk);
        c++;
      end
      check("burst_drained_level", 32'(lvl0), 0);
    end
`else
    check("level_tied_zero", {lvl2, lvl1, lvl0}, 0);
`endif

    c = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("scoreboard_empty", q0.size() + q1.size() + q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
